instr_load_mem: RTL
===================

# instr_load_mem

Parametrised instruction loader and instruction memory. It accepts a stream of instruction words over a valid/ready handshake and writes them into consecutive memory locations, starting at a programmable base address. On completion it publishes the program counter start value, and it gives the fetch stage a registered read port. It sits between the instruction source (file reader in simulation, boot stream in hardware) and the fetch stage. It replaces the fixed 32-bit/1024-entry, unhandshaked shift-to-register path.

## Interface
- DATA_W, 32, instruction word width in bits
- DEPTH, 1024, number of memory words (≥2)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-low; sampled on rising clk
- load_start  input  1  one-cycle request to begin a load (honoured only in IDLE)
- load_base  input  ADDR_W  first write address, sampled with load_start
- load_count  input  ADDR_W+1  number of words to load, sampled with load_start
- in_valid  input  1  source has a word on in_data
- in_data  input  DATA_W  instruction word
- in_ready  output  1  loader accepts in_data this cycle
- load_busy  output  1  high in LOAD state
- load_done  output  1  one-cycle pulse on successful completion
- load_error  output  1  one-cycle pulse when a request is rejected
- word_count  output  ADDR_W+1  words written in current/last load
- program_counter  output  DATA_W  zero-extended load_base of last successful load
- rd_en  input  1  fetch read enable
- rd_addr  input  ADDR_W  fetch address
- rd_data  output  DATA_W  registered read data

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - On load_start, with end = load_base + load_count computed at ADDR_W+2 bits:
    - load_count==0 or end > DEPTH → load_error=1 next cycle; stay IDLE; nothing written.
    - Otherwise → LOAD; wr_ptr←load_base, remaining←load_count, word_count←0; base latched.
- LOAD:
  - in_ready=1, load_busy=1.
  - A word is accepted when in_valid&&in_ready: mem[wr_ptr]←in_data, wr_ptr+1, remaining−1, word_count+1.
  - Accepting the word with remaining==1 → DONE.
  - in_valid low → hold; no state change.
  - load_start is ignored while in LOAD.
- DONE:
  - One cycle; load_done=1, in_ready=0.
  - program_counter←latched base, zero-extended to DATA_W.
  - Next state IDLE.
- wr_ptr never wraps: the range check guarantees the last write address ≤ DEPTH−1.
- Read port:
  - rd_en=1 → rd_data←mem[rd_addr] at the next edge.
  - rd_en=0 → rd_data holds its value.
  - Read and write to the same address in the same cycle returns the old contents.
- Memory contents are not cleared by reset.

## Timing
- Reset (reset==0 at an edge):
  - state→IDLE.
  - in_ready, load_busy, load_done, load_error = 0.
  - word_count=0, program_counter=0, rd_data=0.
  - Reset overrides everything, including a load in progress. Partially written words remain in memory; program_counter stays 0.
- Start latency: load_start at edge N → in_ready=1 from cycle N+1.
- Throughput: one word per cycle when in_valid is held high.
- load_count=K with continuous valid: words written on edges N+1..N+K, load_done high in cycle N+K+1, IDLE and ready for load_start at N+K+2.
- load_error asserts the cycle after the rejected load_start and lasts one cycle.
- Read latency: 1 cycle.
- Boundary: load_base=DEPTH−1, load_count=1 is legal. load_base=DEPTH−1, load_count=2 is rejected.

## Test plan
- Reset mid-load: after 3 of 5 words accepted, drive reset=0 for one cycle → all outputs 0, IDLE. New load_start with base=0x20, count=2 completes normally.
- Basic load: base=0x11, count=5, words 0xA0..0xA4 with valid held high → mem[0x11..0x15]=0xA0..0xA4, load_done 6 cycles after start, program_counter=0x11, word_count=5.
- Backpressure gaps: same load with in_valid low for 2 cycles between each word → identical memory contents; load_busy stays high throughout; no extra writes.
- Range and zero checks (DEPTH=1024):
  - base=1023, count=1 → accepted.
  - base=1023, count=2 → load_error pulse, memory unchanged.
  - count=0 → load_error pulse.
- Ignored start: load_start with base=0x40 pulsed during an active load → ignored; original base and program_counter preserved.
- Read port: read 0x13 after load → rd_data=0xA2 one cycle after rd_en. Read and write to the same address in one cycle → old data returned.

Source files
------------

// File: rtl/instr_load_mem.sv
// Instruction loader and instruction memory.
// Accepts a handshaked stream of instruction words, writes them to consecutive
// addresses starting at a programmable base, publishes the start program
// counter on completion, and offers a one-cycle-latency read port for fetch.
module instr_load_mem #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] program_counter,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // One past the last legal address, widened so base+count cannot overflow.
    localparam logic [ADDR_W+1:0] END_LIMIT = (ADDR_W + 2)'(DEPTH);

    state_t              state_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W:0]     remaining_reg;
    logic [ADDR_W-1:0]   base_reg;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W+1:0]   end_addr;
    logic                start_bad;
    logic                accept;
    logic                last_word;
    logic                wr_en;

    assign end_addr  = {2'b00, load_base} + {1'b0, load_count};
    assign start_bad = (load_count == '0) || (end_addr > END_LIMIT);
    assign accept    = in_valid && in_ready;
    assign last_word = (remaining_reg == (ADDR_W + 1)'(1));
    // A reset edge must not complete a write that was in flight.
    assign wr_en     = accept && reset;

    // Loader FSM with all handshake/status outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            remaining_reg   <= '0;
            base_reg        <= '0;
            in_ready        <= 1'b0;
            load_busy       <= 1'b0;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
            word_count      <= '0;
            program_counter <= '0;
        end else begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        if (start_bad) begin
                            load_error <= 1'b1;
                        end else begin
                            state_reg     <= LOAD;
                            wr_ptr_reg    <= load_base;
                            remaining_reg <= load_count;
                            base_reg      <= load_base;
                            word_count    <= '0;
                            in_ready      <= 1'b1;
                            load_busy     <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr_reg    <= wr_ptr_reg + ADDR_W'(1);
                        remaining_reg <= remaining_reg - (ADDR_W + 1)'(1);
                        word_count    <= word_count + (ADDR_W + 1)'(1);
                        if (last_word) begin
                            state_reg       <= DONE;
                            in_ready        <= 1'b0;
                            load_busy       <= 1'b0;
                            load_done       <= 1'b1;
                            program_counter <= DATA_W'(base_reg);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b0;
                    load_busy <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Registered read port; a same-cycle write to rd_addr yields the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
